// File: rtl/aes_pkg.sv
// Shared AES round-stage types, FSM encoding and GF(2^8) / byte-index helpers.
package aes_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_BITS = 32;
  localparam int unsigned NBYTES = 16;

  typedef logic [7:0]          byte_t;
  typedef logic [COL_BITS-1:0] col_t;
  typedef logic [STATE_W-1:0]  state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } fsm_t;

  localparam byte_t AES_POLY = 8'h1B;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // MSB position of byte idx; byte 0 sits in the top bits of the state.
  function automatic int unsigned byte_msb(input int unsigned idx);
    return STATE_W - 1 - 8 * idx;
  endfunction

  // ShiftRows source: output row r, col c takes input row r, col (c+r)%4.
  function automatic int unsigned sr_src(input int unsigned idx);
    int unsigned row;
    int unsigned col;
    row = idx % 4;
    col = idx / 4;
    return 4 * ((col + row) % 4) + row;
  endfunction

endpackage

// File: rtl/mod_mixcol.sv
// Combinational single-column MixColumns over GF(2^8) with poly 0x11B.
module mod_mixcol
  import aes_pkg::*;
(
  input  col_t column,
  output col_t mixed_c
);

  byte_t b0, b1, b2, b3;
  byte_t x0, x1, x2, x3;

  assign b0 = column[31:24];
  assign b1 = column[23:16];
  assign b2 = column[15:8];
  assign b3 = column[7:0];

  assign x0 = xtime(b0);
  assign x1 = xtime(b1);
  assign x2 = xtime(b2);
  assign x3 = xtime(b3);

  // 3*b is xtime(b)^b, so each row is a sum of doubled and plain terms.
  assign mixed_c[31:24] = x0 ^ (x1 ^ b1) ^ b2 ^ b3;
  assign mixed_c[23:16] = b0 ^ x1 ^ (x2 ^ b2) ^ b3;
  assign mixed_c[15:8]  = b0 ^ b1 ^ x2 ^ (x3 ^ b3);
  assign mixed_c[7:0]   = (x0 ^ b0) ^ b1 ^ b2 ^ x3;

endmodule

// File: rtl/mod_shiftmix.sv
// AES round stage after SubBytes: ShiftRows, column-serial MixColumns, AddRoundKey.
// Define MASK_STRIP_EN to remove the uniform byte mask val during AddRoundKey.
module mod_shiftmix
  import aes_pkg::*;
#(
  parameter int unsigned NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data,
  input  logic [127:0] round_key,
  input  logic         last_round,
  input  logic [7:0]   val,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] s_data_out
);

  localparam int unsigned COL_W = (NCOL > 1) ? $clog2(NCOL) : 1;

`ifdef MASK_STRIP_EN
  localparam bit MASK_STRIP = 1'b1;
`else
  localparam bit MASK_STRIP = 1'b0;
`endif

  fsm_t             fsm_q, fsm_d;
  logic [COL_W-1:0] col_q, col_d;
  state_t           state_q, state_d;
  state_t           key_q, key_d;
  logic             last_q, last_d;
  byte_t            val_q, val_d;
  logic             out_valid_q, out_valid_d;
  state_t           out_q, out_d;

  state_t           sr_c;
  state_t           unmask_c;
  col_t             mix_in_c;
  col_t             mix_out_c;

  // ShiftRows on the incoming SubBytes result.
  always_comb begin
    sr_c = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      sr_c[byte_msb(i) -: 8] = data[byte_msb(sr_src(i)) -: 8];
    end
  end

  always_comb begin
    mix_in_c = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (col_q == COL_W'(c)) mix_in_c = state_q[STATE_W - 1 - COL_BITS * c -: COL_BITS];
    end
  end

  mod_mixcol u_mixcol (
    .column  (mix_in_c),
    .mixed_c (mix_out_c)
  );

  assign unmask_c = MASK_STRIP ? {NBYTES{val_q}} : '0;

  // Next-state and datapath update.
  always_comb begin
    fsm_d       = fsm_q;
    col_d       = col_q;
    state_d     = state_q;
    key_d       = key_q;
    last_d      = last_q;
    val_d       = val_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = sr_c;
          key_d   = round_key;
          last_d  = last_round;
          val_d   = val;
          col_d   = '0;
          fsm_d   = MIX;
        end
      end
      MIX: begin
        // Final round still spends the column cycles so latency stays constant.
        for (int unsigned c = 0; c < NCOL; c++) begin
          if (col_q == COL_W'(c)) begin
            state_d[STATE_W - 1 - COL_BITS * c -: COL_BITS] = last_q ? mix_in_c : mix_out_c;
          end
        end
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(NCOL - 1)) fsm_d = ADD;
      end
      ADD: begin
        state_d     = state_q ^ key_q ^ unmask_c;
        out_d       = state_q ^ key_q ^ unmask_c;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      col_q       <= '0;
      state_q     <= '0;
      key_q       <= '0;
      last_q      <= 1'b0;
      val_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      fsm_q       <= fsm_d;
      col_q       <= col_d;
      state_q     <= state_d;
      key_q       <= key_d;
      last_q      <= last_d;
      val_q       <= val_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign in_ready   = rst_n && (fsm_q == IDLE);
  assign out_valid  = out_valid_q;
  assign s_data_out = out_q;

endmodule

// File: doc/mod_shiftmix.md
Name: mod_shiftmix

Overview:
- Round stage directly downstream of the SubBytes stage.
- Consumes the 128-bit SubBytes result (optionally carrying a uniform byte mask `val`) and applies ShiftRows, then MixColumns, then AddRoundKey.
- MixColumns runs column-serial, one column per cycle, through a single shared column unit. Block is registered, with valid/ready handshakes on both sides.
- Output feeds the next round's SubBytes input or the ciphertext register.

Parameters:
- NCOL, 4, number of state columns processed serially (fixed by AES; used for column counter sizing).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream presents data/round_key/last_round/val
- in_ready  output  1  block can accept (high only in IDLE)
- data  input  128  SubBytes output; byte i = data[127-8i -: 8], row = i%4, col = i/4
- round_key  input  128  round key, same byte order
- last_round  input  1  1 = skip MixColumns (final AES round)
- val  input  8  uniform byte mask present on data
- out_valid  output  1  s_data_out valid
- out_ready  input  1  downstream accepts
- s_data_out  output  128  round result, same byte order

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, col counter=0, out_valid=0, s_data_out=0, internal state register=0. in_ready reads 0 while rst_n=0 and 1 in IDLE afterwards. Reset mid-operation discards the block; no partial output.
- FSM:
  - IDLE: in_ready=1. On in_valid at posedge: latch ShiftRows(data) into state reg (row r rotated left by r columns), latch round_key, last_round and val. Go to MIX, col=0.
  - MIX: each cycle replace column col with mixcol(column), or pass it unchanged if last_round. col++. After col=3, go to ADD.
  - ADD: state ^= round_key, go to DONE.
  - DONE: out_valid=1, s_data_out=state. Hold stable until out_ready. On out_ready go to IDLE and drop out_valid.
- Latency:
  - Accept at edge T. Columns written at T+1..T+4, AddRoundKey at T+5, out_valid high from T+5 (after edge T+5).
  - Latency is constant regardless of last_round, which is required for timing side-channel uniformity.
- Throughput: at most one block per 7 cycles with out_ready tied high. No accept while DONE; in_ready=0 there.
- Inputs (data, round_key, last_round, val) are sampled only on the accept edge. Later changes are ignored.
- Simultaneous in_valid while busy: ignored, upstream holds.
- mixcol arithmetic in GF(2^8) with poly 0x11B: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00). Output rows are [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] times the column.
- Mask property: a uniform mask m on all 16 bytes passes ShiftRows and MixColumns unchanged (2^3^1^1 = 1), so output mask = m on every byte.

Optional Feature:
- Macro MASK_STRIP_EN.
- Defined: in ADD, state ^= round_key ^ {16{val_latched}}, so s_data_out is unmasked.
- Undefined: val is latched but unused, and output stays masked by val.

Decomposition:
- Shared package aes_pkg holds:
  - state/column/byte typedefs
  - FSM state enum (IDLE, MIX, ADD, DONE)
  - AES_POLY constant 8'h1B
  - xtime function
  - byte-index helper functions for ShiftRows mapping
- One sub-module, mod_mixcol: combinational single-column MixColumns, 32-bit in/out, instantiated once.

Test Plan:
- FIPS-197 App. B round 1:
  - Stimulus: data = d42711ae_e0bf98f1_b8b45de5_1e415230, round_key = a0fafe17_88542cb1_23a33939_2a6c7605, last_round=0, val=0.
  - Required: s_data_out = a49c7ff2_689f352b_6b5bea43_026a5049, out_valid rising exactly 5 edges after accept.
- last_round=1, same data, round_key=0 -> s_data_out = d4bf5d30_e0b452ae_b84111f1_1e2798e5 (ShiftRows only), with the same 5-cycle latency.
- Column check with round_key=0, last_round=0:
  - Stimulus: data column 0 bytes db,13,53,45 placed so that ShiftRows keeps them in column 0; all other bytes 0.
  - Required: output column 0 = 8e4da1bc.
- Mask pass-through: case-1 inputs with every data byte XOR 5a and val=5a:
  - Without MASK_STRIP_EN: output = case-1 result ^ {16{5a}}.
  - With MASK_STRIP_EN: output = the case-1 result exactly.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> s_data_out stable, in_ready=0, and a new in_valid is not accepted. Raising out_ready gives one transfer, then in_ready=1 on the next cycle.
- Reset mid-MIX: assert rst_n=0 at T+2 for one cycle -> next cycle out_valid=0, s_data_out=0, in_ready=1, and no output of the aborted block ever appears.
